sipo_deserializer: RTL and testbench
====================================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 Parameter N, default 4: parallel word width in bits; N SHALL be at least 2.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 reset_n  input  1  reset, asynchronous and active-low; asserting it forces reset state immediately, and deassertion is synchronous to clk.
REQ-004 serial_in  input  1  serial data bit.
REQ-005 bit_valid  input  1  serial_in holds a valid bit this cycle.
REQ-006 frame_start  input  1  marks the current bit as bit 0 of a new word.
REQ-007 dir  input  1  bit order: 0 = MSB-first, 1 = LSB-first; sampled only with an accepted frame_start bit.
REQ-008 abort  input  1  discards any partial word and returns to IDLE.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 clr_overrun  input  1  clears the overrun flag.
REQ-011 out_data  output  N  assembled parallel word.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 overrun  output  1  sticky flag: a completed word was dropped.
REQ-014 bit_cnt  output  clog2(N+1)  bits collected in the current partial word.

Function
REQ-015 States: IDLE (not framed) and ACTIVE (framed).
- IDLE -> ACTIVE on bit_valid & frame_start & !abort.
- ACTIVE -> IDLE on abort.
- No other transitions.
REQ-016 In IDLE, a bit SHALL be accepted only when frame_start=1; bits without frame_start SHALL be ignored.
REQ-017 In ACTIVE, every bit_valid=1 cycle SHALL accept one bit.
REQ-018 An accepted bit with frame_start=1 SHALL discard any partial word, latch dir into an internal dir_q, and count as bit 0.
REQ-019 frame_start=1 with bit_valid=0 SHALL have no effect.
REQ-020 Shift on each accepted bit:
- dir_q=0: sh <= {sh[N-2:0], serial_in}.
- dir_q=1: sh <= {serial_in, sh[N-1:1]}.
REQ-021 bit_cnt SHALL increment on each accepted bit, and SHALL wrap to 0 on the Nth bit (word complete).
REQ-022 After a word completes, the block SHALL stay ACTIVE so that the next bit_valid begins the next word with no gap and no frame_start required.
REQ-023 On the clock edge that accepts the Nth bit, the complete word (including that bit) SHALL be loaded into out_data and out_valid SHALL be set, provided out_valid=0 or (out_valid & out_ready) in that cycle. Latency is 0 cycles after the last bit edge.
REQ-024 A transfer SHALL occur at each edge where out_valid & out_ready. With no new word that edge, out_valid SHALL clear. out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 If a word completes while out_valid=1 and out_ready=0:
- the new word is dropped;
- out_data keeps the old word;
- overrun is set to 1.
REQ-026 overrun SHALL clear on clr_overrun=1. If a set condition and clr_overrun occur in the same cycle, set wins.
REQ-027 abort SHALL take priority over bit_valid and frame_start. It zeroes bit_cnt and leaves out_data, out_valid and overrun unchanged.
REQ-028 out_valid SHALL never assert without exactly N bits accepted since the last frame_start or completion.

Reset
REQ-029 While reset_n=0:
- state = IDLE;
- sh, bit_cnt, dir_q = 0;
- out_data = 0, out_valid = 0, overrun = 0.
REQ-030 Reset SHALL discard any partial word and any pending output word. The first bit after reset SHALL be accepted only with frame_start.

Verification (N=4)
REQ-031 MSB-first: frame_start with dir=0, bits 1,0,1,1 on consecutive cycles, out_ready=1 -> after the 4th edge, out_data=4'b1011 and out_valid=1 for one cycle.
REQ-032 LSB-first: frame_start with dir=1, bits 1,0,1,1 -> out_data=4'b1101.
REQ-033 Back-to-back: 8 continuous bits 1,0,0,0,0,1,1,1 with dir=0 and a single frame_start -> words 4'b1000 then 4'b0111, with no overrun.
REQ-034 Backpressure: out_ready=0, two full words sent -> out_data holds the first word, overrun=1. Then out_ready=1 -> first word transfers. Then clr_overrun -> overrun=0.
REQ-035 Resync/abort: 2 bits sent, then frame_start with 4 new bits -> only the new word is output. 3 bits sent, then abort -> bit_cnt=0, state IDLE, and a bit without frame_start is ignored.
REQ-036 Async reset: reset_n=0 asserted mid-word with out_valid=1 -> all outputs go to 0 before the next clk edge; after release, 4 bits without frame_start produce no output.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with framing, selectable bit order,
// a one-word output holding register and a sticky overrun flag.
module sipo_deserializer #(
  parameter int N = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       frame_start,
  input  logic                       dir,
  input  logic                       abort,
  input  logic                       out_ready,
  input  logic                       clr_overrun,
  output logic [N-1:0]               out_data,
  output logic                       out_valid,
  output logic                       overrun,
  output logic [$clog2(N+1)-1:0]     bit_cnt
);

  localparam int CW = $clog2(N+1);
  localparam logic [CW-1:0] LP_N = CW'(N);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_sh;
  logic [CW-1:0]   r_bit_cnt;
  logic            r_dir_q;
  logic [N-1:0]    r_out_data;
  logic            r_out_valid;
  logic            r_overrun;

  logic            w_accept;
  logic            w_start;
  logic            w_dir;
  logic [N-1:0]    w_sh_base;
  logic [N-1:0]    w_sh_next;
  logic [CW-1:0]   w_cnt_base;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_complete;
  logic            w_can_load;

  // A bit is taken when framed, or when it opens a new frame; abort masks all.
  assign w_accept   = bit_valid & ~abort & ((r_state == ACTIVE) | frame_start);
  assign w_start    = w_accept & frame_start;
  // A frame-start bit already uses the newly presented bit order.
  assign w_dir      = frame_start ? dir : r_dir_q;
  assign w_sh_base  = w_start ? '0 : r_sh;
  assign w_sh_next  = w_dir ? {serial_in, w_sh_base[N-1:1]}
                            : {w_sh_base[N-2:0], serial_in};
  assign w_cnt_base = w_start ? '0 : r_bit_cnt;
  assign w_cnt_inc  = w_cnt_base + 1'b1;
  assign w_complete = w_accept & (w_cnt_inc == LP_N);
  assign w_can_load = ~r_out_valid | out_ready;

  // Framing state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Framing next state: open on an accepted frame-start bit, close on abort.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bit_valid && frame_start && !abort) w_state_next = ACTIVE;
      ACTIVE:  if (abort) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Shift register, bit counter and latched bit order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
      r_dir_q   <= 1'b0;
    end else if (abort) begin
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_sh      <= w_sh_next;
      r_bit_cnt <= w_complete ? '0 : w_cnt_inc;
      if (w_start) r_dir_q <= dir;
    end
  end

  // Output holding register with handshake, plus sticky overrun (set beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_complete && w_can_load) begin
        r_out_data  <= w_sh_next;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_complete && !w_can_load) r_overrun <= 1'b1;
      else if (clr_overrun)          r_overrun <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scenario bench for sipo_deserializer (N=4) with an expected-word queue.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       dir = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [3:0] out_data;
  logic       out_valid;
  logic       overrun;
  logic [2:0] bit_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_w;

  sipo_deserializer #(.N(4)) dut (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .dir(dir), .abort(abort), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .out_data(out_data), .out_valid(out_valid),
    .overrun(overrun), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, return 1 time unit after the rising edge.
  task automatic cycle(input logic bv, input logic b, input logic fs, input logic d,
                       input logic ab, input logic clr);
    @(negedge clk);
    bit_valid = bv; serial_in = b; frame_start = fs; dir = d; abort = ab; clr_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_data !== 4'h0) $display("FAIL rst_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", overrun); else n_pass++;
    n_checks++; if (bit_cnt !== 3'd0) $display("FAIL rst_cnt: got %0d want 0", bit_cnt); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_msb_first();
    logic [3:0] bits;
    bits = 4'b1011;
    out_ready = 1'b1;
    exp_q.push_back(4'b1011);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bits[3-i], (i == 0), 1'b0, 1'b0, 1'b0);
      if (i < 3) begin
        n_checks++; if (bit_cnt !== 3'(i + 1)) $display("FAIL msb_cnt%0d: got %0d want %0d", i, bit_cnt, i + 1); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL msb_early_valid%0d: got %b want 0", i, out_valid); else n_pass++;
      end
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL msb_valid: got %b want 1", out_valid); else n_pass++;
    exp_w = exp_q.pop_front();
    n_checks++; if (out_data !== exp_w) $display("FAIL msb_data: got %b want %b", out_data, exp_w); else n_pass++;
    n_checks++; if (bit_cnt !== 3'd0) $display("FAIL msb_cnt_wrap: got %0d want 0", bit_cnt); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL msb_valid_clear: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_lsb_first();
    logic [3:0] bits;
    bits = 4'b1011;
    out_ready = 1'b1;
    exp_q.push_back(4'b1101);
    for (int i = 0; i < 4; i++) cycle(1'b1, bits[3-i], (i == 0), 1'b1, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL lsb_valid: got %b want 1", out_valid); else n_pass++;
    exp_w = exp_q.pop_front();
    n_checks++; if (out_data !== exp_w) $display("FAIL lsb_data: got %b want %b", out_data, exp_w); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    bits = 8'b1000_0111;
    out_ready = 1'b1;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0111);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, bits[7-i], (i == 0), 1'b0, 1'b0, 1'b0);
      if (i == 3 || i == 7) begin
        n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid%0d: got %b want 1", i, out_valid); else n_pass++;
        exp_w = exp_q.pop_front();
        n_checks++; if (out_data !== exp_w) $display("FAIL b2b_data%0d: got %b want %b", i, out_data, exp_w); else n_pass++;
      end else if (i > 3) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_gap%0d: got %b want 0", i, out_valid); else n_pass++;
      end
    end
    n_checks++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL b2b_queue: got %0d want 0", exp_q.size()); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [7:0] bits;
    bits = 8'b1010_0101;
    out_ready = 1'b0;
    exp_q.push_back(4'b1010);  // second word is expected to be dropped
    for (int i = 0; i < 8; i++) cycle(1'b1, bits[7-i], (i == 0), 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_q[0]) $display("FAIL bp_hold: got %b want %b", out_data, exp_q[0]); else n_pass++;
    n_checks++; if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", overrun); else n_pass++;
    @(negedge clk);
    out_ready = 1'b1;
    exp_w = exp_q.pop_front();
    n_checks++; if (out_data !== exp_w) $display("FAIL bp_xfer_data: got %b want %b", out_data, exp_w); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_xfer_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (overrun !== 1'b1) $display("FAIL bp_sticky: got %b want 1", overrun); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (overrun !== 1'b0) $display("FAIL bp_clr: got %b want 0", overrun); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_resync_abort();
    logic [3:0] bits;
    out_ready = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bits = 4'b0110;
    exp_q.push_back(4'b0110);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bits[3-i], (i == 0), 1'b0, 1'b0, 1'b0);
      if (i < 3) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL resync_early%0d: got %b want 0", i, out_valid); else n_pass++;
      end
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL resync_valid: got %b want 1", out_valid); else n_pass++;
    exp_w = exp_q.pop_front();
    n_checks++; if (out_data !== exp_w) $display("FAIL resync_data: got %b want %b", out_data, exp_w); else n_pass++;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, (i == 0), 1'b0, 1'b0, 1'b0);
    n_checks++; if (bit_cnt !== 3'd3) $display("FAIL abort_pre_cnt: got %0d want 3", bit_cnt); else n_pass++;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (bit_cnt !== 3'd0) $display("FAIL abort_cnt: got %0d want 0", bit_cnt); else n_pass++;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (bit_cnt !== 3'd0) $display("FAIL abort_idle_cnt: got %0d want 0", bit_cnt); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL abort_idle_valid: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    bits = 4'b1100;
    out_ready = 1'b0;
    exp_q.push_back(4'b1100);
    for (int i = 0; i < 4; i++) cycle(1'b1, bits[3-i], (i == 0), 1'b0, 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL ar_valid: got %b want 1", out_valid); else n_pass++;
    exp_w = exp_q.pop_front();
    n_checks++; if (out_data !== exp_w) $display("FAIL ar_data: got %b want %b", out_data, exp_w); else n_pass++;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (out_data !== 4'h0) $display("FAIL ar_async_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ar_async_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ar_async_overrun: got %b want 0", overrun); else n_pass++;
    n_checks++; if (bit_cnt !== 3'd0) $display("FAIL ar_async_cnt: got %0d want 0", bit_cnt); else n_pass++;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL ar_post_valid%0d: got %b want 0", i, out_valid); else n_pass++;
    end
    n_checks++; if (bit_cnt !== 3'd0) $display("FAIL ar_post_cnt: got %0d want 0", bit_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_backpressure();
    test_resync_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
